mul8_seq: RTL



---
 rtl/mul8_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/mul8_seq.sv
// Sequential 8x8 shift-and-add multiplier built around one add8 adder/subtractor.
// Define MUL8_SEQ_SIGNED_EN for two's-complement signed operands (unsigned otherwise).

module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [7:0] s,
    output logic       cout
);
    // Subtract as a + ~b + 1; cin is inverted so it acts as a borrow-in.
    assign {cout, s} = {1'b0, a} + {1'b0, b ^ {8{sub}}} + {8'b0, cin ^ sub};
endmodule

module mul8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state;
    logic [7:0]  mcand;
    logic [16:0] acc;
    logic [2:0]  cnt;
    logic [7:0]  sum;
    logic        cout;
    logic        sub_step;
    logic [8:0]  hi_new;
    logic        fill;
    logic [16:0] acc_nxt;

`ifdef MUL8_SEQ_SIGNED_EN
    assign sub_step = (cnt == 3'd7);
`else
    assign sub_step = 1'b0;
`endif

    add8 u_add (
        .a    (acc[15:8]),
        .b    (mcand),
        .cin  (1'b0),
        .sub  (sub_step),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        hi_new = acc[16:8];
        fill   = 1'b0;
`ifdef MUL8_SEQ_SIGNED_EN
        // 9th bit of the sign-extended sum; arithmetic shift keeps it.
        if (acc[0])
            hi_new = {acc[15] ^ mcand[7] ^ sub_step ^ cout, sum};
        fill = hi_new[8];
`else
        if (acc[0])
            hi_new = {cout, sum};
`endif
        acc_nxt = {fill, hi_new, acc[7:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= 16'h0000;
            acc   <= 17'd0;
            cnt   <= 3'd0;
            mcand <= 8'd0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        acc   <= {9'b0, b};
                        cnt   <= 3'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        p     <= acc_nxt[15:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
